// File: rtl/ps2_player_input_pkg.sv
// ---------------------------------------------------------------------------
// ps2_player_input_pkg
// Shared types and constants for the PS/2 player input path:
//   - key_idx_t   : index of each tracked key inside the held[] vector
//   - dec_state_t : scan-code decoder states
//   - dir_t       : last horizontal direction pressed
//   - PS/2 Set 2 prefix bytes and keyboard status bytes to ignore
//   - default key maps for player 1 and player 2
// ---------------------------------------------------------------------------
package ps2_player_input_pkg;

    localparam int NUM_KEYS = 5;

    typedef enum logic [2:0] {
        K_RIGHT  = 3'd0,
        K_LEFT   = 3'd1,
        K_JUMP   = 3'd2,
        K_SQUAT  = 3'd3,
        K_DEFEND = 3'd4
    } key_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_t;

    // Prefix bytes
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;

    // Keyboard status / protocol bytes that carry no key information
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;

    // Player 1: D / A / W / S / F
    localparam logic [7:0] P1_KEY_RIGHT  = 8'h23;
    localparam logic [7:0] P1_KEY_LEFT   = 8'h1C;
    localparam logic [7:0] P1_KEY_JUMP   = 8'h1D;
    localparam logic [7:0] P1_KEY_SQUAT  = 8'h1B;
    localparam logic [7:0] P1_KEY_DEFEND = 8'h2B;

    // Player 2: L / J / I / K / O
    localparam logic [7:0] P2_KEY_RIGHT  = 8'h4B;
    localparam logic [7:0] P2_KEY_LEFT   = 8'h3B;
    localparam logic [7:0] P2_KEY_JUMP   = 8'h43;
    localparam logic [7:0] P2_KEY_SQUAT  = 8'h42;
    localparam logic [7:0] P2_KEY_DEFEND = 8'h44;

    localparam logic [19:0] DEFAULT_TIMEOUT = 20'd500000;

    function automatic logic is_ignorable(input logic [7:0] code);
        return (code == PS2_BAT_OK) || (code == PS2_ACK)  ||
               (code == PS2_RESEND) || (code == PS2_ECHO) ||
               (code == PS2_PAUSE);
    endfunction

endpackage

// File: rtl/ps2_player_input_if.sv
// ---------------------------------------------------------------------------
// ps2_player_input_if
// Byte stream from the PS/2 receiver into the player input decoder.
//   scan_valid : one-cycle strobe, scan_code holds a new byte
//   scan_code  : received PS/2 byte
// Modports: master (byte receiver side), slave (decoder side).
// ---------------------------------------------------------------------------
interface ps2_player_input_if;

    logic       scan_valid;
    logic [7:0] scan_code;

    modport master (output scan_valid, output scan_code);
    modport slave  (input  scan_valid, input  scan_code);

endinterface

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// Tracks the Set 2 prefix sequence (E0 / F0 / E0 F0) and reports completed
// make and break codes for the five mapped keys.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   scan_valid   : byte strobe
//   scan_code    : byte value
//   make_valid   : this cycle's byte is a make of a mapped key
//   break_valid  : this cycle's byte is a break of a mapped key
//   key_idx      : which mapped key (valid with make_valid/break_valid)
// make/break are decoded combinationally from the current state and the
// incoming byte so the top level can fold them into the same cycle's frame.
// ---------------------------------------------------------------------------
module ps2_key_decoder
    import ps2_player_input_pkg::*;
#(
    parameter logic [7:0]  KEY_RIGHT  = P1_KEY_RIGHT,
    parameter logic [7:0]  KEY_LEFT   = P1_KEY_LEFT,
    parameter logic [7:0]  KEY_JUMP   = P1_KEY_JUMP,
    parameter logic [7:0]  KEY_SQUAT  = P1_KEY_SQUAT,
    parameter logic [7:0]  KEY_DEFEND = P1_KEY_DEFEND,
    parameter logic [19:0] TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic       make_valid,
    output logic       break_valid,
    output key_idx_t   key_idx
);

    localparam logic [19:0] TO_LAST = TIMEOUT - 20'd1;

    dec_state_t  state;
    logic [19:0] idle_cnt;
    logic        key_hit;

    // Key map lookup
    always_comb begin
        key_hit = 1'b1;
        key_idx = K_RIGHT;
        if (scan_code == KEY_RIGHT)       key_idx = K_RIGHT;
        else if (scan_code == KEY_LEFT)   key_idx = K_LEFT;
        else if (scan_code == KEY_JUMP)   key_idx = K_JUMP;
        else if (scan_code == KEY_SQUAT)  key_idx = K_SQUAT;
        else if (scan_code == KEY_DEFEND) key_idx = K_DEFEND;
        else                              key_hit = 1'b0;
    end

    // Prefix bytes and status bytes seen in IDLE never count as makes
    always_comb begin
        make_valid  = scan_valid && (state == ST_IDLE) && key_hit &&
                      (scan_code != PS2_EXT) && (scan_code != PS2_BRK) &&
                      !is_ignorable(scan_code);
        break_valid = scan_valid && (state == ST_BRK) && key_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idle_cnt <= '0;
        end else if (scan_valid) begin
            idle_cnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (scan_code == PS2_EXT)      state <= ST_EXT;
                    else if (scan_code == PS2_BRK) state <= ST_BRK;
                end
                ST_EXT:     state <= (scan_code == PS2_BRK) ? ST_EXT_BRK : ST_IDLE;
                ST_BRK:     state <= ST_IDLE;
                ST_EXT_BRK: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end else if (state != ST_IDLE) begin
            // A stalled prefix (lost byte, unplugged keyboard) must not
            // swallow the next real make code forever.
            if (idle_cnt == TO_LAST) begin
                state    <= ST_IDLE;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 20'd1;
            end
        end
    end

endmodule

// File: rtl/ps2_player_input.sv
// ---------------------------------------------------------------------------
// ps2_player_input
// Turns a PS/2 Set 2 byte stream into frame-synchronous movement commands
// for one player.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : byte stream (scan_valid / scan_code), slave side
//   frame_en   : one-cycle strobe per game update
//   right/left : horizontal move this frame (never both)
//   jump       : one frame per jump key press
//   squat      : squat key held
//   defend     : defend key held
// Outputs update only on frame_en and are computed from the next-state key
// vector, so a byte arriving on the strobe cycle is already reflected.
// ---------------------------------------------------------------------------
module ps2_player_input
    import ps2_player_input_pkg::*;
#(
    parameter logic [7:0]  KEY_RIGHT  = 8'h23,
    parameter logic [7:0]  KEY_LEFT   = 8'h1C,
    parameter logic [7:0]  KEY_JUMP   = 8'h1D,
    parameter logic [7:0]  KEY_SQUAT  = 8'h1B,
    parameter logic [7:0]  KEY_DEFEND = 8'h2B,
    parameter logic [19:0] TIMEOUT    = 20'd500000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ps2_player_input_if.slave        bus,
    input  logic                     frame_en,
    output logic                     right,
    output logic                     left,
    output logic                     jump,
    output logic                     squat,
    output logic                     defend
);

    logic                make_valid;
    logic                break_valid;
    key_idx_t            key_idx;

    logic [NUM_KEYS-1:0] held;
    logic [NUM_KEYS-1:0] held_nxt;
    dir_t                last_dir;
    dir_t                last_dir_nxt;
    logic                jump_pend;
    logic                press_new;
    logic                jump_press_now;

    ps2_key_decoder #(
        .KEY_RIGHT  (KEY_RIGHT),
        .KEY_LEFT   (KEY_LEFT),
        .KEY_JUMP   (KEY_JUMP),
        .KEY_SQUAT  (KEY_SQUAT),
        .KEY_DEFEND (KEY_DEFEND),
        .TIMEOUT    (TIMEOUT)
    ) u_decoder (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_valid  (bus.scan_valid),
        .scan_code   (bus.scan_code),
        .make_valid  (make_valid),
        .break_valid (break_valid),
        .key_idx     (key_idx)
    );

    // A "new" press is a make of a key not already held; typematic repeats
    // of a held key are not presses.
    always_comb begin
        held_nxt       = held;
        last_dir_nxt   = last_dir;
        press_new      = make_valid && !held[key_idx];
        jump_press_now = press_new && (key_idx == K_JUMP);
        if (make_valid)  held_nxt[key_idx] = 1'b1;
        if (break_valid) held_nxt[key_idx] = 1'b0;
        if (press_new && (key_idx == K_RIGHT))     last_dir_nxt = DIR_RIGHT;
        else if (press_new && (key_idx == K_LEFT)) last_dir_nxt = DIR_LEFT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held      <= '0;
            last_dir  <= DIR_RIGHT;
            jump_pend <= 1'b0;
            right     <= 1'b0;
            left      <= 1'b0;
            jump      <= 1'b0;
            squat     <= 1'b0;
            defend    <= 1'b0;
        end else begin
            held     <= held_nxt;
            last_dir <= last_dir_nxt;
            if (frame_en) begin
                // With both directions held the most recent press wins,
                // which keeps right and left mutually exclusive.
                right     <= held_nxt[K_RIGHT] &
                             (~held_nxt[K_LEFT] | (last_dir_nxt == DIR_RIGHT));
                left      <= held_nxt[K_LEFT] &
                             (~held_nxt[K_RIGHT] | (last_dir_nxt == DIR_LEFT));
                squat     <= held_nxt[K_SQUAT];
                defend    <= held_nxt[K_DEFEND];
                jump      <= jump_pend | jump_press_now;
                jump_pend <= 1'b0;
            end else begin
                jump_pend <= jump_pend | jump_press_now;
            end
        end
    end

endmodule

// File: tb/tb_ps2_player_input.sv
module tb_ps2_player_input;

    localparam logic [19:0] TB_TIMEOUT = 20'd16;
    localparam int          TO_INT     = 16;

    logic clk;
    logic rst_n;
    logic frame_en;
    logic right, left, jump, squat, defend;
    int   checks;
    int   errors;

    ps2_player_input_if bus ();

    ps2_player_input #(
        .KEY_RIGHT  (8'h23),
        .KEY_LEFT   (8'h1C),
        .KEY_JUMP   (8'h1D),
        .KEY_SQUAT  (8'h1B),
        .KEY_DEFEND (8'h2B),
        .TIMEOUT    (TB_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .frame_en (frame_en),
        .right    (right),
        .left     (left),
        .jump     (jump),
        .squat    (squat),
        .defend   (defend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.scan_valid = 1'b1;
        bus.scan_code  = b;
        @(negedge clk);
        bus.scan_valid = 1'b0;
    endtask

    task automatic send_byte_frame(input logic [7:0] b);
        @(negedge clk);
        bus.scan_valid = 1'b1;
        bus.scan_code  = b;
        frame_en       = 1'b1;
        @(negedge clk);
        bus.scan_valid = 1'b0;
        frame_en       = 1'b0;
    endtask

    task automatic frame();
        @(negedge clk);
        frame_en = 1'b1;
        @(negedge clk);
        frame_en = 1'b0;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        frame_en       = 1'b0;
        bus.scan_valid = 1'b0;
        bus.scan_code  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_right",  right,  1'b0);
        check("reset_left",   left,   1'b0);
        check("reset_jump",   jump,   1'b0);
        check("reset_squat",  squat,  1'b0);
        check("reset_defend", defend, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Simple right press / release
        send_byte(8'h23);
        check("right_before_frame", right, 1'b0);
        frame();
        check("right_make_r", right, 1'b1);
        check("right_make_l", left,  1'b0);
        send_byte(8'hF0);
        send_byte(8'h23);
        frame();
        check("right_break_r", right, 1'b0);

        // Both held: most recent press wins
        send_byte(8'h1C);
        send_byte(8'h23);
        frame();
        check("both_r", right, 1'b1);
        check("both_l", left,  1'b0);
        send_byte(8'hF0);
        send_byte(8'h23);
        frame();
        check("relD_r", right, 1'b0);
        check("relD_l", left,  1'b1);
        send_byte(8'hF0);
        send_byte(8'h1C);
        frame();
        check("relA_l", left, 1'b0);

        // Typematic jump repeats give one jump frame
        repeat (5) send_byte(8'h1D);
        frame();
        check("typ_jump_f1", jump, 1'b1);
        frame();
        check("typ_jump_f2", jump, 1'b0);
        frame();
        check("typ_jump_f3", jump, 1'b0);
        send_byte(8'hF0);
        send_byte(8'h1D);

        // Press and release between strobes
        send_byte(8'h1D);
        send_byte(8'hF0);
        send_byte(8'h1D);
        frame();
        check("tap_jump_f1", jump, 1'b1);
        frame();
        check("tap_jump_f2", jump, 1'b0);

        // Jump press on the strobe cycle
        send_byte_frame(8'h1D);
        check("coinc_jump_f1", jump, 1'b1);
        frame();
        check("coinc_jump_f2", jump, 1'b0);
        send_byte(8'hF0);
        send_byte(8'h1D);

        // Right make on the strobe cycle is visible in that frame
        send_byte_frame(8'h23);
        check("coinc_right", right, 1'b1);
        send_byte(8'hF0);
        send_byte(8'h23);
        frame();
        check("coinc_right_rel", right, 1'b0);

        // Extended codes do not touch mapped keys
        send_byte(8'hE0);
        send_byte(8'h23);
        frame();
        check("ext_make_r", right, 1'b0);
        send_byte(8'h23);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h23);
        frame();
        check("ext_break_r", right, 1'b1);
        send_byte(8'hF0);
        send_byte(8'h23);
        frame();
        check("ext_real_rel", right, 1'b0);

        // Status byte in IDLE is ignored; next make still decodes
        send_byte(8'hAA);
        send_byte(8'h2B);
        frame();
        check("ign_defend", defend, 1'b1);
        send_byte(8'hF0);
        send_byte(8'h2B);
        frame();
        check("ign_defend_rel", defend, 1'b0);

        // Stalled break prefix times out; next byte is a make
        send_byte(8'hF0);
        repeat (TO_INT - 1) @(negedge clk);
        send_byte(8'h1B);
        frame();
        check("timeout_squat", squat, 1'b1);
        // One idle cycle short of the timeout: still a break
        send_byte(8'hF0);
        repeat (TO_INT - 2) @(negedge clk);
        send_byte(8'h1B);
        frame();
        check("no_timeout_squat", squat, 1'b0);

        // Mid-operation reset
        send_byte(8'h2B);
        send_byte(8'h1B);
        frame();
        check("pre_rst_defend", defend, 1'b1);
        check("pre_rst_squat",  squat,  1'b1);
        send_byte(8'hF0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_now_defend", defend, 1'b0);
        check("rst_now_squat",  squat,  1'b0);
        check("rst_now_right",  right,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        frame();
        check("post_rst_defend", defend, 1'b0);
        check("post_rst_squat",  squat,  1'b0);
        check("post_rst_jump",   jump,   1'b0);
        // Partial F0 before reset is lost: 1B is a make
        send_byte(8'h1B);
        frame();
        check("post_rst_make", squat, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_player_input.md
Name: ps2_player_input

Overview:
- Upstream stage of the player controller. Decodes a PS/2 keyboard scan-code byte stream (Set 2) into per-key held state.
- Produces frame-synchronous movement commands: right, left, jump, squat, defend. Jump is a one-shot per key press.
- Sits between the PS/2 byte receiver and one player's position/jump logic. Instantiate one per player, each with its own key map.

Parameters:
- KEY_RIGHT, 8'h23, make code for right (D)
- KEY_LEFT, 8'h1C, make code for left (A)
- KEY_JUMP, 8'h1D, make code for jump (W)
- KEY_SQUAT, 8'h1B, make code for squat (S)
- KEY_DEFEND, 8'h2B, make code for defend (F)
- TIMEOUT, 20'd500000, max idle cycles allowed inside a prefix sequence before returning to IDLE

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- scan_valid  in  1  one-cycle strobe: scan_code holds a new byte
- scan_code  in  8  received PS/2 byte
- frame_en  in  1  one-cycle strobe once per game update
- right  out  1  move right this frame
- left  out  1  move left this frame
- jump  out  1  jump request this frame (one frame per press)
- squat  out  1  squat held
- defend  out  1  defend held

Behaviour:
- Reset (async): all outputs 0, held[4:0]=0, jump_pend=0, last_dir=RIGHT, FSM=IDLE, timeout counter=0.
- Bytes are processed only on cycles where scan_valid=1. scan_code is ignored otherwise.
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: 8'hE0 -> EXT; 8'hF0 -> BRK. Any other byte is a make code: if it matches a key, set that held bit. Stay in IDLE.
  - EXT: 8'hF0 -> EXT_BRK; any other byte is discarded (extended make) -> IDLE.
  - BRK: byte is a break code; if it matches a key, clear that held bit -> IDLE.
  - EXT_BRK: byte discarded -> IDLE.
  - Bytes 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1 received in IDLE are ignored and change no state.
- Timeout: the counter increments every cycle while FSM != IDLE and scan_valid=0, and resets on any byte. When it reaches TIMEOUT-1, FSM -> IDLE and the counter clears. held bits are unchanged.
- Jump edge: a make of KEY_JUMP while held[JUMP]=0 sets jump_pend. Typematic repeats, where held is already 1, do not.
- last_dir: updated to RIGHT or LEFT on a make of that key while it is not already held.
- Outputs are registered and update only on frame_en cycles; they hold between strobes. On a frame_en cycle:
  - right <= held[R] & (~held[L] | last_dir==RIGHT)
  - left <= held[L] & (~held[R] | last_dir==LEFT)
  - Invariant: right and left are never both 1.
  - squat <= held[S]; defend <= held[D]
  - jump <= jump_pend | jump_press_now; jump_pend <= 0
- Simultaneous events, same cycle:
  - A byte and frame_en: the byte's effect on held/last_dir is visible in that frame's outputs (outputs are computed from next-state held).
  - A new jump press and frame_en: the press is emitted this frame and not retained.
- Press and release of jump between two strobes still yields jump=1 for exactly one frame.
- Latency: a byte completing a make/break is reflected at the next frame_en, or at the same cycle's frame_en if coincident. Output registers change the cycle after that strobe.
- Mid-operation reset: everything returns to reset values immediately. A partial sequence in progress is lost.

Decomposition:
- Shared package (input pkg): key-index enum (K_RIGHT..K_DEFEND), decoder state enum, PS/2 constants (PS2_EXT=8'hE0, PS2_BRK=8'hF0, ignorable codes), and default key maps for player 1 and player 2.
- Sub-module ps2_key_decoder: the FSM plus timeout, emitting make_valid/break_valid with a 3-bit key index. The top level holds held/last_dir/jump_pend and the frame output register.

Test Plan:
- Make 8'h23, then frame_en -> right=1, left=0. Then F0 23 and frame_en -> right=0.
- Hold A (1C), then press D (23), frame_en -> right=1, left=0. Release D (F0 23), frame_en -> left=1.
- Make 1D repeated 5 times (typematic), then frame_en x3 -> jump=1 on the first frame only, 0 on the next two.
- 1D, F0 1D, all between strobes, then frame_en -> jump=1 for one frame. Also: 1D on the same cycle as frame_en -> jump=1 on that frame, 0 on the next.
- E0 23 then E0 F0 23 -> no held change, right stays 0. Then F0 only, then TIMEOUT idle cycles, then 1B and frame_en -> FSM back in IDLE, squat=1.
- Hold 2B and 1B, then assert rst_n=0 mid-frame -> all outputs 0 immediately. After release and frame_en with no bytes -> all outputs 0.
